// File: rtl/instfetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a single-outstanding req/gnt/rvalid port.
// Optional FETCH_PERF_CNT_EN adds fetch_stall_cnt, a saturating count of cycles spent fetching with nothing presented.
module instfetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc2,
    output logic [31:0] instr2,
    output logic        instr_valid2,
    output logic        instruction_addr_misaligned2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    // state  | meaning
    // S_REQ  | request pc_q, wait for grant
    // S_WAIT | request granted, waiting for response (dropped if kill_q)
    // S_HOLD | response buffered while decode stalls
    // S_MISAL| misaligned target, report once when not stalled
    // S_IDLE | misalignment reported, idle until next redirect
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_MISAL, S_IDLE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc2_q, pc2_d;
    logic [31:0] instr2_q, instr2_d;
    logic        valid2_q, valid2_d;
    logic        mis2_q, mis2_d;
    state_t      redir_state, resume_state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            buf_q    <= NOP_INSTR;
            pc2_q    <= RESET_PC;
            instr2_q <= NOP_INSTR;
            valid2_q <= 1'b0;
            mis2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            buf_q    <= buf_d;
            pc2_q    <= pc2_d;
            instr2_q <= instr2_d;
            valid2_q <= valid2_d;
            mis2_q   <= mis2_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        buf_d        = buf_q;
        pc2_d        = pc2_q;
        instr2_d     = instr2_q;
        valid2_d     = valid2_q;
        mis2_d       = mis2_q;
        redir_state  = (redirect_pc[1:0] != 2'b00) ? S_MISAL : S_REQ;
        resume_state = (pc_q[1:0] != 2'b00) ? S_MISAL : S_REQ;
        // state_q resets to S_REQ, so gate the request while reset is held
        imem_req     = (state_q == S_REQ) && nrst;
        imem_addr    = pc_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            instr2_d = NOP_INSTR;
            valid2_d = 1'b0;
            mis2_d   = 1'b0;
            kill_d   = 1'b0;
            state_d  = redir_state;
            // an access is still outstanding: wait for its response and drop it
            if ((state_q == S_REQ && imem_gnt) || (state_q == S_WAIT && !imem_rvalid)) begin
                state_d = S_WAIT;
                kill_d  = 1'b1;
            end
        end else begin
            if (!stall) begin
                instr2_d = NOP_INSTR;
                valid2_d = 1'b0;
                mis2_d   = 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = resume_state;
                        end else if (!stall) begin
                            pc2_d    = pc_q;
                            instr2_d = imem_rdata;
                            valid2_d = 1'b1;
                            pc_d     = pc_q + 32'd4;
                            state_d  = S_REQ;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc2_d    = pc_q;
                        instr2_d = buf_q;
                        valid2_d = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_REQ;
                    end
                end
                S_MISAL: begin
                    if (!stall) begin
                        pc2_d   = pc_q;
                        mis2_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    assign pc2                          = pc2_q;
    assign instr2                       = instr2_q;
    assign instr_valid2                 = valid2_q;
    assign instruction_addr_misaligned2 = mis2_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= 32'd0;
        end else if ((state_q == S_REQ || state_q == S_WAIT) && !valid2_q && cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign fetch_stall_cnt = cnt_q;
`endif

endmodule
